// File: rtl/gpp_seq_pkg.sv
// Shared definitions for the gpp_sequencer: FSM states, opcodes, flag bits
// and coprocessor channel numbers.
package gpp_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC     = 3'd3,
        S_WAIT_COP = 3'd4,
        S_WB       = 3'd5,
        S_HALT     = 3'd6
    } state_e;

    localparam logic [5:0] OP_HLT     = 6'h00;
    localparam logic [5:0] OP_LDA     = 6'h01;
    localparam logic [5:0] OP_STA     = 6'h02;
    localparam logic [5:0] OP_LDR     = 6'h03;
    localparam logic [5:0] OP_STR     = 6'h04;
    localparam logic [5:0] OP_BRZ     = 6'h05;
    localparam logic [5:0] OP_BRN     = 6'h06;
    localparam logic [5:0] OP_JMP     = 6'h07;
    localparam logic [5:0] OP_CALL    = 6'h08;
    localparam logic [5:0] OP_RET     = 6'h09;
    localparam logic [5:0] OP_CRYPT   = 6'h0A;
    localparam logic [5:0] OP_DECRYPT = 6'h0B;
    localparam logic [5:0] OP_ALU_LO  = 6'h10;
    localparam logic [5:0] OP_ALU_HI  = 6'h1F;

    // Bit positions inside flags = {zero, negative, carry, overflow}
    localparam int FLAG_ZERO  = 3;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

    localparam int COP_ALU    = 0;
    localparam int COP_CRYPTO = 1;

    // True for the opcode block that is dispatched to the ALU coprocessor
    function automatic logic is_alu_op(input logic [5:0] opc);
        return (opc >= OP_ALU_LO) && (opc <= OP_ALU_HI);
    endfunction

endpackage

// File: rtl/gpp_ret_stack.sv
// Return-address LIFO for CALL/RET. Push is refused when full, pop is
// refused when empty; clr empties the stack in one cycle.
module gpp_ret_stack
    import gpp_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]   cnt_q;
    logic [PW:0]   cnt_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_idx_s;
    logic [PW-1:0] rd_idx_s;

    assign wr_idx_s = cnt_q[PW-1:0];
    assign rd_idx_s = cnt_q[PW-1:0] - PW'(1);
    assign full     = (cnt_q == (PW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign top_data = mem_q[rd_idx_s];

    // Next occupancy: clear beats push, push beats pop
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (push && !full) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Occupancy counter with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents above the count are don't-care so no reset
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem_q[wr_idx_s] <= push_data;
        end
    end

endmodule

// File: rtl/gpp_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with return-address stack and
// a uniform start/done handshake towards N_COP coprocessors.
// Optional build macro GPP_SEQ_WATCHDOG_EN bounds the coprocessor wait with
// a 16-bit watchdog that faults the sequencer on expiry.
// Opcodes are 6 bits wide; OPC_W is kept as a parameter for the field slice.
module gpp_sequencer
    import gpp_seq_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int OPC_W       = 6,
    parameter int ADDR_W      = 9,
    parameter int STACK_DEPTH = 8,
    parameter int N_COP       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bgn,
    input  logic [DATA_W-1:0] instr,
    input  logic [3:0]        flags,
    input  logic [N_COP-1:0]  cop_done,
    output logic [ADDR_W-1:0] pc,
    output logic              imem_rd,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic [ADDR_W-1:0] addr,
    output logic              reg_sel,
    output logic              reg_rd,
    output logic              reg_wr,
    output logic              acc_ld,
    output logic              acc_st,
    output logic [N_COP-1:0]  cop_start,
    output logic              cop_mode,
    output logic [N_COP-1:0]  cop_wb,
    output logic              fin,
    output logic              err
);
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic               imem_rd_q, imem_rd_d;
    logic               dmem_rd_q, dmem_rd_d;
    logic               dmem_wr_q, dmem_wr_d;
    logic               reg_rd_q, reg_rd_d;
    logic               reg_wr_q, reg_wr_d;
    logic               acc_ld_q, acc_ld_d;
    logic               acc_st_q, acc_st_d;
    logic [N_COP-1:0]   cop_start_q, cop_start_d;
    logic               cop_mode_q, cop_mode_d;
    logic [N_COP-1:0]   cop_wb_q, cop_wb_d;
    logic [N_COP-1:0]   cop_wait_q, cop_wait_d;
    logic               fin_q, fin_d;
    logic               err_q, err_d;
`ifdef GPP_SEQ_WATCHDOG_EN
    logic [15:0]        wdog_q, wdog_d;
`endif

    logic [5:0]         in_opc_s;
    logic [5:0]         ir_opc_s;
    logic [ADDR_W-1:0]  ir_addr_s;
    logic [ADDR_W-1:0]  pc_inc_s;
    logic               push_s, pop_s, clr_s;
    logic [ADDR_W-1:0]  stk_top_s;
    logic               stk_full_s, stk_empty_s;
    logic               flags_unused_s;

    assign in_opc_s       = 6'(instr[DATA_W-1 -: OPC_W]);
    assign ir_opc_s       = 6'(ir_q[DATA_W-1 -: OPC_W]);
    assign ir_addr_s      = ir_q[ADDR_W-1:0];
    assign pc_inc_s       = pc_q + ADDR_W'(1);
    assign flags_unused_s = ^{flags[FLAG_CARRY], flags[FLAG_OVF]};

    gpp_ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top_data  (stk_top_s),
        .full      (stk_full_s),
        .empty     (stk_empty_s)
    );

    // Next-state and next-output logic; strobes default low every cycle
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imem_rd_d   = 1'b0;
        dmem_rd_d   = 1'b0;
        dmem_wr_d   = 1'b0;
        reg_rd_d    = 1'b0;
        reg_wr_d    = 1'b0;
        acc_ld_d    = 1'b0;
        acc_st_d    = 1'b0;
        cop_start_d = '0;
        cop_mode_d  = 1'b0;
        cop_wb_d    = '0;
        cop_wait_d  = cop_wait_q;
        fin_d       = fin_q;
        err_d       = err_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        clr_s       = 1'b0;
`ifdef GPP_SEQ_WATCHDOG_EN
        wdog_d      = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bgn) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    imem_rd_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Strobes are registered, so they are decoded from the
                // incoming word to appear during the EXEC cycle
                ir_d    = instr;
                state_d = S_EXEC;
                case (in_opc_s)
                    OP_LDA:     begin dmem_rd_d = 1'b1; acc_ld_d = 1'b1; end
                    OP_STA:     begin acc_st_d  = 1'b1; dmem_wr_d = 1'b1; end
                    OP_LDR:     begin dmem_rd_d = 1'b1; reg_wr_d = 1'b1; end
                    OP_STR:     begin reg_rd_d  = 1'b1; dmem_wr_d = 1'b1; end
                    OP_CRYPT:   begin cop_start_d[COP_CRYPTO] = 1'b1; end
                    OP_DECRYPT: begin cop_start_d[COP_CRYPTO] = 1'b1; cop_mode_d = 1'b1; end
                    default: begin
                        if (is_alu_op(in_opc_s)) begin
                            reg_rd_d             = 1'b1;
                            cop_start_d[COP_ALU] = 1'b1;
                        end else begin
                            reg_rd_d = 1'b0;
                        end
                    end
                endcase
            end
            S_EXEC: begin
                state_d   = S_FETCH;
                pc_d      = pc_inc_s;
                imem_rd_d = 1'b1;
                case (ir_opc_s)
                    OP_HLT: begin
                        state_d = S_HALT; pc_d = pc_q; imem_rd_d = 1'b0; fin_d = 1'b1;
                    end
                    OP_LDA, OP_STA, OP_LDR, OP_STR: begin
                        pc_d = pc_inc_s;
                    end
                    OP_BRZ: pc_d = flags[FLAG_ZERO] ? ir_addr_s : pc_inc_s;
                    OP_BRN: pc_d = flags[FLAG_NEG]  ? ir_addr_s : pc_inc_s;
                    OP_JMP: pc_d = ir_addr_s;
                    OP_CALL: begin
                        if (stk_full_s) begin
                            state_d = S_HALT; pc_d = pc_q; imem_rd_d = 1'b0; err_d = 1'b1;
                        end else begin
                            push_s = 1'b1; pc_d = ir_addr_s;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty_s) begin
                            state_d = S_HALT; pc_d = pc_q; imem_rd_d = 1'b0; err_d = 1'b1;
                        end else begin
                            pop_s = 1'b1; pc_d = stk_top_s;
                        end
                    end
                    OP_CRYPT, OP_DECRYPT: begin
                        state_d    = S_WAIT_COP; pc_d = pc_q; imem_rd_d = 1'b0;
                        cop_wait_d = '0;
                        cop_wait_d[COP_CRYPTO] = 1'b1;
                        cop_mode_d = cop_mode_q;
`ifdef GPP_SEQ_WATCHDOG_EN
                        wdog_d     = '0;
`endif
                    end
                    default: begin
                        if (is_alu_op(ir_opc_s)) begin
                            state_d    = S_WAIT_COP; pc_d = pc_q; imem_rd_d = 1'b0;
                            cop_wait_d = '0;
                            cop_wait_d[COP_ALU] = 1'b1;
`ifdef GPP_SEQ_WATCHDOG_EN
                            wdog_d     = '0;
`endif
                        end else begin
                            state_d = S_HALT; pc_d = pc_q; imem_rd_d = 1'b0; err_d = 1'b1;
                        end
                    end
                endcase
            end
            S_WAIT_COP: begin
                cop_mode_d = cop_mode_q;
`ifdef GPP_SEQ_WATCHDOG_EN
                if (wdog_q == 16'hFFFF) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else if (|(cop_done & cop_wait_q)) begin
                    state_d  = S_WB;
                    cop_wb_d = cop_wait_q;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
`else
                if (|(cop_done & cop_wait_q)) begin
                    state_d  = S_WB;
                    cop_wb_d = cop_wait_q;
                end else begin
                    state_d = S_WAIT_COP;
                end
`endif
            end
            S_WB: begin
                state_d   = S_FETCH;
                pc_d      = pc_inc_s;
                imem_rd_d = 1'b1;
            end
            S_HALT: begin
                if (bgn) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    imem_rd_d = 1'b1;
                    fin_d     = 1'b0;
                    err_d     = 1'b0;
                    clr_s     = 1'b1;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Single state/output register bank with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            imem_rd_q   <= 1'b0;
            dmem_rd_q   <= 1'b0;
            dmem_wr_q   <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            acc_ld_q    <= 1'b0;
            acc_st_q    <= 1'b0;
            cop_start_q <= '0;
            cop_mode_q  <= 1'b0;
            cop_wb_q    <= '0;
            cop_wait_q  <= '0;
            fin_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef GPP_SEQ_WATCHDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            imem_rd_q   <= imem_rd_d;
            dmem_rd_q   <= dmem_rd_d;
            dmem_wr_q   <= dmem_wr_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            acc_ld_q    <= acc_ld_d;
            acc_st_q    <= acc_st_d;
            cop_start_q <= cop_start_d;
            cop_mode_q  <= cop_mode_d;
            cop_wb_q    <= cop_wb_d;
            cop_wait_q  <= cop_wait_d;
            fin_q       <= fin_d;
            err_q       <= err_d;
`ifdef GPP_SEQ_WATCHDOG_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign pc        = pc_q;
    assign imem_rd   = imem_rd_q;
    assign dmem_rd   = dmem_rd_q;
    assign dmem_wr   = dmem_wr_q;
    assign addr      = ir_addr_s;
    assign reg_sel   = ir_q[ADDR_W];
    assign reg_rd    = reg_rd_q;
    assign reg_wr    = reg_wr_q;
    assign acc_ld    = acc_ld_q;
    assign acc_st    = acc_st_q;
    assign cop_start = cop_start_q;
    assign cop_mode  = cop_mode_q;
    assign cop_wb    = cop_wb_q;
    assign fin       = fin_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gpp_sequencer.sv
// Directed, self-checking bench for gpp_sequencer: a cycle table for a short
// load/store/halt program plus hand-written coprocessor, branch, stack,
// reset and fault sequences.
module tb_gpp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bgn;
    logic [15:0] instr;
    logic [3:0]  flags;
    logic [1:0]  cop_done;
    logic [8:0]  pc;
    logic        imem_rd, dmem_rd, dmem_wr;
    logic [8:0]  addr;
    logic        reg_sel, reg_rd, reg_wr, acc_ld, acc_st;
    logic [1:0]  cop_start;
    logic        cop_mode;
    logic [1:0]  cop_wb;
    logic        fin, err;

    logic [15:0] imem [512];
    int          n_checks = 0;
    int          n_fail   = 0;

    gpp_sequencer dut (
        .clk(clk), .rst(rst), .bgn(bgn), .instr(instr), .flags(flags),
        .cop_done(cop_done), .pc(pc), .imem_rd(imem_rd), .dmem_rd(dmem_rd),
        .dmem_wr(dmem_wr), .addr(addr), .reg_sel(reg_sel), .reg_rd(reg_rd),
        .reg_wr(reg_wr), .acc_ld(acc_ld), .acc_st(acc_st),
        .cop_start(cop_start), .cop_mode(cop_mode), .cop_wb(cop_wb),
        .fin(fin), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after imem_rd
    always @(posedge clk) begin
        if (rst) instr <= 16'h0000;
        else if (imem_rd) instr <= imem[pc];
    end

    typedef struct {
        logic       bgn;
        logic [8:0] pc;
        logic       imem_rd, dmem_rd, dmem_wr, acc_ld, acc_st;
        logic [8:0] addr;
        logic       fin, err;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [15:0] ins(input logic [5:0] op, input logic [9:0] a);
        return {op, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1; bgn = 1'b0; flags = 4'b0000; cop_done = 2'b00;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Pulse bgn; returns in the first FETCH cycle
    task automatic start_prog();
        bgn = 1'b1; tick(); bgn = 1'b0;
    endtask

    // Advance one non-cop instruction and check the next fetch address
    task automatic next_fetch(input string name, input logic [8:0] exp_pc);
        tick(); tick(); tick();
        chk({name, "_imem_rd"}, 32'(imem_rd), 32'd1);
        chk({name, "_pc"}, 32'(pc), 32'(exp_pc));
    endtask

    initial begin
        // bgn  pc     im dr dw al as addr  fin err
        vecs[0]  = '{1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd5, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 9'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd5, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd5, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 9'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd6, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 9'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd6, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 9'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd6, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 9'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 9'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 9'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0};

        // ---- reset state ----
        clear_mem();
        do_reset();
        rst = 1'b1; tick();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_strobes", 32'({imem_rd, dmem_rd, dmem_wr, reg_rd, reg_wr, acc_ld, acc_st}), 32'd0);
        chk("rst_cop", 32'({cop_start, cop_wb, cop_mode}), 32'd0);
        chk("rst_fin_err", 32'({fin, err}), 32'd0);
        rst = 1'b0;

        // ---- table: LDA 5, STA 6, HLT, then restart from HALT ----
        imem[0] = ins(6'h01, 10'h005);
        imem[1] = ins(6'h02, 10'h006);
        imem[2] = ins(6'h00, 10'h000);
        for (int i = 0; i < 13; i++) begin
            bgn = vecs[i].bgn;
            tick();
            bgn = 1'b0;
            chk($sformatf("tab%0d_pc", i), 32'(pc), 32'(vecs[i].pc));
            chk($sformatf("tab%0d_imem_rd", i), 32'(imem_rd), 32'(vecs[i].imem_rd));
            chk($sformatf("tab%0d_dmem", i), 32'({dmem_rd, dmem_wr}), 32'({vecs[i].dmem_rd, vecs[i].dmem_wr}));
            chk($sformatf("tab%0d_acc", i), 32'({acc_ld, acc_st}), 32'({vecs[i].acc_ld, vecs[i].acc_st}));
            chk($sformatf("tab%0d_addr", i), 32'(addr), 32'(vecs[i].addr));
            chk($sformatf("tab%0d_fin_err", i), 32'({fin, err}), 32'({vecs[i].fin, vecs[i].err}));
        end

        // ---- ALU coprocessor handshake ----
        clear_mem();
        imem[0] = ins(6'h10, 10'h000);
        imem[1] = ins(6'h00, 10'h000);
        do_reset();
        start_prog(); tick(); tick();
        chk("alu_start", 32'(cop_start), 32'd1);
        chk("alu_reg_rd", 32'(reg_rd), 32'd1);
        cop_done = 2'b01;                      // same cycle as start: ignored
        tick();
        cop_done = 2'b10; bgn = 1'b1;          // wrong channel, bgn while busy
        chk("alu_start_1cyc", 32'(cop_start), 32'd0);
        chk("alu_wb_early", 32'(cop_wb), 32'd0);
        tick();
        cop_done = 2'b00; bgn = 1'b0;
        chk("alu_wb_other_ch", 32'(cop_wb), 32'd0);
        chk("alu_bgn_ignored", 32'({imem_rd, pc}), 32'd0);
        tick(); tick();
        cop_done = 2'b01;                      // 4 cycles after cop_start
        tick();
        cop_done = 2'b00;
        chk("alu_wb", 32'(cop_wb), 32'd1);
        tick();
        chk("alu_wb_1cyc", 32'(cop_wb), 32'd0);
        chk("alu_next_fetch", 32'({imem_rd, pc}), 32'({1'b1, 9'd1}));
        tick(); tick(); tick();
        chk("alu_fin", 32'({fin, err}), 32'b10);

        // ---- DECRYPT on crypto channel ----
        clear_mem();
        imem[0] = ins(6'h0B, 10'h000);
        do_reset();
        start_prog(); tick(); tick();
        chk("dec_start", 32'({cop_start, cop_mode}), 32'b101);
        tick();
        cop_done = 2'b01;                      // ALU channel: not the one waited on
        tick();
        cop_done = 2'b10;
        chk("dec_wb_wrong", 32'(cop_wb), 32'd0);
        tick();
        cop_done = 2'b00;
        chk("dec_wb", 32'(cop_wb), 32'b10);

        // ---- branches and PC wrap ----
        clear_mem();
        imem[9'h000] = ins(6'h05, 10'h040);    // BRZ 0x40
        imem[9'h040] = ins(6'h05, 10'h080);    // BRZ 0x80
        imem[9'h041] = ins(6'h07, 10'h1FF);    // JMP 0x1FF
        imem[9'h1FF] = ins(6'h01, 10'h000);    // LDA 0
        imem[9'h001] = ins(6'h06, 10'h020);    // BRN 0x20
        do_reset();
        flags = 4'b1000;
        start_prog();
        next_fetch("brz_taken", 9'h040);
        flags = 4'b0000;
        next_fetch("brz_not_taken", 9'h041);
        flags = 4'b0100;
        next_fetch("jmp", 9'h1FF);
        next_fetch("pc_wrap", 9'h000);
        next_fetch("brz_zero_clear", 9'h001);
        next_fetch("brn_taken", 9'h020);
        flags = 4'b0000;

        // ---- stack overflow: 8 nested CALLs, 9th faults ----
        clear_mem();
        for (int i = 0; i < 9; i++) imem[i] = ins(6'h08, 10'(i + 1));
        do_reset();
        start_prog();
        for (int i = 0; i < 8; i++) next_fetch($sformatf("call%0d", i), 9'(i + 1));
        tick(); tick(); tick();
        chk("call_ovf_fin_err", 32'({fin, err}), 32'b01);
        chk("call_ovf_pc", 32'(pc), 32'd8);

        // ---- RET on empty stack after restart from HALT ----
        imem[0] = ins(6'h09, 10'h000);
        start_prog();
        chk("restart_clears", 32'({fin, err, pc}), 32'd0);
        tick(); tick(); tick();
        chk("ret_empty_err", 32'({fin, err}), 32'b01);

        // ---- CALL/RET round trip ----
        clear_mem();
        imem[9'h000] = ins(6'h08, 10'h100);
        imem[9'h100] = ins(6'h09, 10'h000);
        do_reset();
        start_prog();
        next_fetch("call_ok", 9'h100);
        next_fetch("ret_ok", 9'h001);
        tick(); tick(); tick();
        chk("callret_fin", 32'({fin, err}), 32'b10);

        // ---- reset during WAIT_COP ----
        clear_mem();
        imem[0] = ins(6'h10, 10'h000);
        do_reset();
        start_prog(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_outputs", 32'({pc, imem_rd, cop_start, cop_wb, fin, err}), 32'd0);
        cop_done = 2'b01;
        tick();
        cop_done = 2'b00;
        tick();
        chk("rstw_idle", 32'({imem_rd, cop_wb}), 32'd0);
        start_prog();
        chk("rstw_restart", 32'({imem_rd, pc}), 32'({1'b1, 9'd0}));

        // ---- illegal opcode ----
        clear_mem();
        imem[0] = ins(6'h3F, 10'h000);
        do_reset();
        start_prog(); tick(); tick(); tick();
        chk("illegal_op", 32'({fin, err}), 32'b01);

`ifdef GPP_SEQ_WATCHDOG_EN
        // ---- watchdog expiry with no cop_done ----
        begin
            int waited;
            clear_mem();
            imem[0] = ins(6'h10, 10'h000);
            do_reset();
            start_prog(); tick(); tick();
            waited = 0;
            while (!err && waited < 70000) begin
                tick();
                waited++;
            end
            chk("wdog_cycles", 32'(waited), 32'd65537);
            cop_done = 2'b01;
            tick();
            cop_done = 2'b00;
            chk("wdog_late_done", 32'({cop_wb, err}), 32'b001);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpp_sequencer.md
Name: gpp_sequencer

Overview:
Parametrised multi-cycle fetch/decode/execute sequencer for the general-purpose processor. It drives the instruction memory, data memory, register file and accumulator strobes. It holds the PC and an internal return-address stack. It starts N_COP coprocessors (channel 0 = ALU, channel 1 = crypto core) through a uniform start/done handshake, replacing the fixed control-signal fan-out of the current CPU top.

Parameters:
DATA_W, 16, instruction word width
OPC_W, 6, opcode field width, instr[DATA_W-1 -: OPC_W]
ADDR_W, 9, address/immediate field width, instr[ADDR_W-1:0]; PC width
STACK_DEPTH, 8, return-address stack entries (power of 2, >=2)
N_COP, 2, coprocessor channels (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
bgn  in  1  start pulse; program begins at PC 0
instr  in  DATA_W  instruction memory read data, valid 1 cycle after imem_rd
flags  in  4  {zero,negative,carry,overflow} from ALU
cop_done  in  N_COP  per-channel single-cycle completion pulse
pc  out  ADDR_W  current PC / instruction memory address
imem_rd  out  1  instruction read strobe
dmem_rd  out  1  data memory read
dmem_wr  out  1  data memory write
addr  out  ADDR_W  operand address/immediate from IR
reg_sel  out  1  IR bit ADDR_W: 0=X, 1=Y
reg_rd, reg_wr  out  1  register-file read/write strobe for reg_sel
acc_ld, acc_st  out  1  accumulator load from mem / store to mem
cop_start  out  N_COP  one-hot single-cycle start
cop_mode  out  1  crypto mode: 0 encrypt, 1 decrypt
cop_wb  out  N_COP  one-hot write-back strobe after completion
fin  out  1  program halted normally
err  out  1  halted on fault

Behaviour:
- All outputs registered. Reset: state IDLE, pc=0, stack empty. All strobes, fin and err are 0. Reset mid-instruction aborts immediately and drops any pending cop wait.
- States: IDLE, FETCH, DECODE, EXEC, WAIT_COP, WB, HALT.
- IDLE: bgn=1 -> FETCH with pc=0.
- FETCH: imem_rd=1 for one cycle -> DECODE.
- DECODE: IR<=instr; -> EXEC.
- EXEC: one cycle of strobes per opcode, then pc<=pc+1 (mod 2^ADDR_W) -> FETCH, unless stated otherwise. A non-cop instruction therefore takes 3 cycles.
- Opcodes:
  - 00 HLT -> HALT, fin=1.
  - 01 LDA: dmem_rd, acc_ld.
  - 02 STA: acc_st, dmem_wr.
  - 03 LDR: dmem_rd, reg_wr.
  - 04 STR: reg_rd, dmem_wr.
  - 05 BRZ: pc<=addr if flags[3], else pc+1.
  - 06 BRN: same, using flags[2].
  - 07 JMP: pc<=addr.
  - 08 CALL: push pc+1, pc<=addr.
  - 09 RET: pop into pc.
  - 0A CRYPT / 0B DECRYPT: cop_start[1], cop_mode=0/1.
  - 10-1F ALU ops: reg_rd, cop_start[0].
  - Any other opcode -> HALT, err=1.
- Cop ops: EXEC -> WAIT_COP on the started channel k. WAIT_COP ignores cop_done on other channels. On cop_done[k] -> WB. WB: cop_wb[k]=1 for one cycle, pc+1 -> FETCH. A done pulse in the same cycle as cop_start is not expected and is ignored.
- Stack: CALL when full -> err, HALT, pc unchanged. RET when empty -> err, HALT. Stack depth at reset = 0.
- HALT: strobes 0; fin/err held. bgn=1 clears fin and err, empties the stack, pc=0 -> FETCH.
- bgn is ignored outside IDLE and HALT.

Optional Feature:
GPP_SEQ_WATCHDOG_EN: adds a 16-bit counter cleared on entry to WAIT_COP. If it reaches 16'hFFFF before cop_done[k], the sequencer sets err=1 -> HALT, and cop_done arriving afterwards is ignored. Without the macro, WAIT_COP waits indefinitely.

Decomposition:
- Package gpp_seq_pkg holds:
  - state enum;
  - opcode constants (OP_HLT … OP_DECRYPT, OP_ALU_LO=6'h10, OP_ALU_HI=6'h1F);
  - flag bit indices;
  - cop channel indices COP_ALU=0, COP_CRYPTO=1.
- One sub-module, gpp_ret_stack: parametrised LIFO with push/pop/full/empty and synchronous reset.

Test Plan:
- Program {LDA 5, STA 6, HLT}: imem_rd at cycles 1, 4, 7 after bgn. Pulses dmem_rd+acc_ld, then acc_st+dmem_wr. fin=1 with pc=2.
- ALU op 6'h10: cop_start=2'b01 for one cycle. cop_done[0] asserted 4 cycles later gives cop_wb=2'b01 the next cycle. A cop_done[1] pulse while waiting on channel 0 has no effect.
- BRZ 0x40 with flags=4'b1000 gives pc=0x40; with flags=0 gives pc+1. JMP from pc=0x1FF wraps normally, and pc+1 from 0x1FF gives 0.
- CALL nested 8 deep succeeds; the 9th CALL gives err=1, fin=0. RET on an empty stack gives err=1.
- Reset asserted during WAIT_COP: next cycle all outputs 0 and state IDLE. bgn restarts at pc=0.
- Opcode 6'h3F gives err=1. With GPP_SEQ_WATCHDOG_EN and no cop_done, err=1 after 65535 wait cycles.
